// File: rtl/rx_hp_pkg.sv
// Shared types and helpers for the huge-page address register block.
// Holds TLP fmt/type codes, decoder states and address-range helpers.
package rx_hp_pkg;

    localparam logic [6:0] MWR32 = 7'b10_00000;
    localparam logic [6:0] MWR64 = 7'b11_00000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR3,
        S_HDR4,
        S_DATA,
        S_DRAIN
    } rx_state_e;

    function automatic logic [31:0] byteswap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    function automatic int offset_w(input int n);
        return $clog2(3 * n);
    endfunction

    // True when a write of one or two DWs at byte address a misses the map.
    function automatic logic range_bad(input logic [31:0] a,
                                       input logic        two,
                                       input int          n);
        int          ow;
        int          off;
        logic [31:0] mask;
        ow   = offset_w(n);
        mask = (32'd1 << ow) - 32'd1;
        off  = int'((a >> 2) & mask);
        return ((a >> (ow + 2)) != 32'd0) || ((off + int'(two)) >= 3 * n);
    endfunction

endpackage

// File: rtl/rx_hp_addr_regs_decode.sv
// Memory-write TLP parser: header decode, address staging, range checks.
// Emits a combinational commit strobe on the accepted, clean EOF beat.
module rx_mwr_decode
    import rx_hp_pkg::*;
#(
    parameter int NUM_PAGES = 4,
    parameter int BAR_IDX   = 2,
    parameter int OFFSET_W  = 4
) (
    input  logic                trn_clk,
    input  logic                reset_n,
    input  logic [63:0]         trn_rd,
    input  logic                trn_rsof_n,
    input  logic                trn_reof_n,
    input  logic                trn_rsrc_rdy_n,
    input  logic                trn_rsrc_dsc_n,
    input  logic [6:0]          trn_rbar_hit_n,
    input  logic                trn_rdst_rdy_n,
    output logic                cmt_vld,
    output logic [OFFSET_W-1:0] cmt_off,
    output logic                cmt_two,
    output logic [31:0]         cmt_d0,
    output logic [31:0]         cmt_d1,
    output logic                wr_err
);

    rx_state_e   state;
    logic        two_q;
    logic        is4_q;
    logic [31:0] addr_q;
    logic [31:0] d0_q;

    logic        acc;
    logic        sof;
    logic        eof;
    logic        dsc;
    logic [31:0] hi_dw;
    logic [31:0] lo_dw;
    logic [6:0]  hdr_ft;
    logic [9:0]  hdr_len;
    logic        hit;
    logic        is_mwr;
    logic        len_ok;
    logic        bad3;
    logic        bad4;

    assign acc     = !trn_rsrc_rdy_n && !trn_rdst_rdy_n;
    assign sof     = !trn_rsof_n;
    assign eof     = !trn_reof_n;
    assign dsc     = !trn_rsrc_dsc_n;
    assign hi_dw   = trn_rd[63:32];
    assign lo_dw   = trn_rd[31:0];
    assign hdr_ft  = hi_dw[30:24];
    assign hdr_len = hi_dw[9:0];
    assign hit     = !trn_rbar_hit_n[BAR_IDX];
    assign is_mwr  = (hdr_ft == MWR32) || (hdr_ft == MWR64);
    assign len_ok  = (hdr_len == 10'd1) || (hdr_len == 10'd2);
    assign bad3    = range_bad(hi_dw, two_q, NUM_PAGES);
    assign bad4    = (hi_dw != 32'd0) || range_bad(lo_dw, two_q, NUM_PAGES);

    // Commit strobe, offset and payload for the EOF beat being accepted
    always_comb begin
        cmt_vld = 1'b0;
        cmt_off = addr_q[OFFSET_W+1:2];
        cmt_two = two_q;
        cmt_d0  = d0_q;
        cmt_d1  = byteswap32(hi_dw);
        unique case (state)
            S_HDR3: begin
                if (acc && eof && !dsc && !two_q && !bad3) begin
                    cmt_vld = 1'b1;
                    cmt_off = hi_dw[OFFSET_W+1:2];
                    cmt_d0  = byteswap32(lo_dw);
                end
            end
            S_DATA: begin
                if (acc && eof && !dsc) begin
                    cmt_vld = 1'b1;
                    if (is4_q) begin
                        cmt_d0 = byteswap32(hi_dw);
                        cmt_d1 = byteswap32(lo_dw);
                    end
                end
            end
            default: ;
        endcase
    end

    // Parser FSM with staging registers and the registered drop pulse
    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            two_q  <= 1'b0;
            is4_q  <= 1'b0;
            addr_q <= '0;
            d0_q   <= '0;
            wr_err <= 1'b0;
        end else begin
            wr_err <= 1'b0;
            if (acc) begin
                unique case (state)
                    S_IDLE: begin
                        if (sof) begin
                            if (hit && is_mwr) begin
                                if (!len_ok || dsc || eof) begin
                                    wr_err <= 1'b1;
                                    state  <= eof ? S_IDLE : S_DRAIN;
                                end else begin
                                    two_q <= (hdr_len == 10'd2);
                                    is4_q <= (hdr_ft == MWR64);
                                    state <= (hdr_ft == MWR64) ? S_HDR4
                                                               : S_HDR3;
                                end
                            end else if (!eof) begin
                                state <= S_DRAIN;
                            end
                        end
                    end
                    S_HDR3: begin
                        addr_q <= hi_dw;
                        d0_q   <= byteswap32(lo_dw);
                        if (dsc || bad3 || (eof == two_q)) begin
                            wr_err <= 1'b1;
                            state  <= eof ? S_IDLE : S_DRAIN;
                        end else begin
                            state <= eof ? S_IDLE : S_DATA;
                        end
                    end
                    S_HDR4: begin
                        addr_q <= lo_dw;
                        if (dsc || bad4 || eof) begin
                            wr_err <= 1'b1;
                            state  <= eof ? S_IDLE : S_DRAIN;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (dsc || !eof) begin
                            wr_err <= 1'b1;
                        end
                        state <= eof ? S_IDLE : S_DRAIN;
                    end
                    S_DRAIN: begin
                        if (eof) begin
                            state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/rx_hp_addr_regs.sv
// Huge-page address registers and ownership status fed by RX MWr TLPs.
// Writes land on the EOF edge; doorbells hand pages to the DMA path.
module rx_hp_addr_regs
    import rx_hp_pkg::*;
#(
    parameter int NUM_PAGES = 4,
    parameter int BAR_IDX   = 2
) (
    input  logic                      trn_clk,
    input  logic                      reset_n,
    input  logic [63:0]               trn_rd,
    input  logic [7:0]                trn_rrem_n,
    input  logic                      trn_rsof_n,
    input  logic                      trn_reof_n,
    input  logic                      trn_rsrc_rdy_n,
    input  logic                      trn_rsrc_dsc_n,
    input  logic [6:0]                trn_rbar_hit_n,
    input  logic                      trn_rdst_rdy_n,
    output logic [64*NUM_PAGES-1:0]   hp_addr,
    output logic [NUM_PAGES-1:0]      hp_status,
    input  logic [NUM_PAGES-1:0]      hp_free,
    output logic                      hp_wr_err
);

    localparam int OFFSET_W = offset_w(NUM_PAGES);

    logic                    cmt_vld;
    logic [OFFSET_W-1:0]     cmt_off;
    logic                    cmt_two;
    logic [31:0]             cmt_d0;
    logic [31:0]             cmt_d1;
    logic [64*NUM_PAGES-1:0] addr_nxt;
    logic [NUM_PAGES-1:0]    stat_nxt;
    int                      dw_off;
    logic [31:0]             dw_val;

    rx_mwr_decode #(
        .NUM_PAGES (NUM_PAGES),
        .BAR_IDX   (BAR_IDX),
        .OFFSET_W  (OFFSET_W)
    ) u_dec (
        .trn_clk        (trn_clk),
        .reset_n        (reset_n),
        .trn_rd         (trn_rd),
        .trn_rsof_n     (trn_rsof_n),
        .trn_reof_n     (trn_reof_n),
        .trn_rsrc_rdy_n (trn_rsrc_rdy_n),
        .trn_rsrc_dsc_n (trn_rsrc_dsc_n),
        .trn_rbar_hit_n (trn_rbar_hit_n),
        .trn_rdst_rdy_n (trn_rdst_rdy_n),
        .cmt_vld        (cmt_vld),
        .cmt_off        (cmt_off),
        .cmt_two        (cmt_two),
        .cmt_d0         (cmt_d0),
        .cmt_d1         (cmt_d1),
        .wr_err         (hp_wr_err)
    );

    // Decode committed DWs into address halves or doorbells; set beats free
    always_comb begin
        addr_nxt = hp_addr;
        stat_nxt = hp_status & ~hp_free;
        dw_off   = 0;
        dw_val   = '0;
        if (cmt_vld) begin
            for (int k = 0; k < 2; k++) begin
                if (k == 0 || cmt_two) begin
                    dw_off = int'(cmt_off) + k;
                    dw_val = (k == 0) ? cmt_d0 : cmt_d1;
                    for (int i = 0; i < NUM_PAGES; i++) begin
                        if (dw_off == 2 * i) begin
                            addr_nxt[64*i +: 32] = dw_val;
                        end
                        if (dw_off == 2 * i + 1) begin
                            addr_nxt[64*i+32 +: 32] = dw_val;
                        end
                        if (dw_off == 2 * NUM_PAGES + i) begin
                            stat_nxt[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Register file and page ownership state
    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            hp_addr   <= '0;
            hp_status <= '0;
        end else begin
            hp_addr   <= addr_nxt;
            hp_status <= stat_nxt;
        end
    end

endmodule

// File: tb/tb_rx_hp_addr_regs.sv
// Directed bench for rx_hp_addr_regs with a queue-based scoreboard.
// Output events (value change or error pulse) are popped and compared.
module tb_rx_hp_addr_regs;

    localparam int         NP   = 4;
    localparam logic [6:0] BAR2 = 7'b1111011;
    localparam logic [6:0] BAR0 = 7'b1111110;

    typedef struct {
        logic [64*NP-1:0] a;
        logic [NP-1:0]    s;
        logic             e;
    } exp_t;

    logic              trn_clk = 1'b0;
    logic              reset_n;
    logic [63:0]       trn_rd;
    logic [7:0]        trn_rrem_n;
    logic              trn_rsof_n;
    logic              trn_reof_n;
    logic              trn_rsrc_rdy_n;
    logic              trn_rsrc_dsc_n;
    logic [6:0]        trn_rbar_hit_n;
    logic              trn_rdst_rdy_n;
    logic [64*NP-1:0]  hp_addr;
    logic [NP-1:0]     hp_status;
    logic [NP-1:0]     hp_free;
    logic              hp_wr_err;

    int                vectors = 0;
    int                miscompares = 0;
    exp_t              exp_q[$];
    logic [64*NP-1:0]  ea = '0;
    logic [NP-1:0]     es = '0;

    rx_hp_addr_regs #(.NUM_PAGES(NP), .BAR_IDX(2)) dut (
        .trn_clk        (trn_clk),
        .reset_n        (reset_n),
        .trn_rd         (trn_rd),
        .trn_rrem_n     (trn_rrem_n),
        .trn_rsof_n     (trn_rsof_n),
        .trn_reof_n     (trn_reof_n),
        .trn_rsrc_rdy_n (trn_rsrc_rdy_n),
        .trn_rsrc_dsc_n (trn_rsrc_dsc_n),
        .trn_rbar_hit_n (trn_rbar_hit_n),
        .trn_rdst_rdy_n (trn_rdst_rdy_n),
        .hp_addr        (hp_addr),
        .hp_status      (hp_status),
        .hp_free        (hp_free),
        .hp_wr_err      (hp_wr_err)
    );

    always #5 trn_clk = ~trn_clk;

    function automatic logic [31:0] dw0(input logic [6:0] ft,
                                        input logic [9:0] len);
        return {1'b0, ft, 14'b0, len};
    endfunction

    task automatic push(input logic e);
        exp_t x;
        x.a = ea;
        x.s = es;
        x.e = e;
        exp_q.push_back(x);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge trn_clk);
            #1;
        end
    endtask

    task automatic beat(input logic [63:0] d, input logic sof,
                        input logic eof, input logic dsc = 1'b0,
                        input logic [6:0] bar = BAR2, input int stall = 0);
        trn_rd         = d;
        trn_rsof_n     = !sof;
        trn_reof_n     = !eof;
        trn_rsrc_dsc_n = !dsc;
        trn_rbar_hit_n = bar;
        trn_rsrc_rdy_n = 1'b0;
        trn_rdst_rdy_n = 1'b1;
        repeat (stall) begin
            @(posedge trn_clk);
            #1;
        end
        trn_rdst_rdy_n = 1'b0;
        @(posedge trn_clk);
        #1;
        trn_rsrc_rdy_n = 1'b1;
        trn_rsof_n     = 1'b1;
        trn_reof_n     = 1'b1;
        trn_rsrc_dsc_n = 1'b1;
        trn_rbar_hit_n = '1;
    endtask

    task automatic mwr3(input logic [31:0] adr, input logic [9:0] len,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic dsc_last, input logic [6:0] bar);
        beat({dw0(7'b10_00000, len), 32'h0000_00FF}, 1'b1, 1'b0,
             1'b0, bar);
        if (len == 10'd1) begin
            beat({adr, d0}, 1'b0, 1'b1, dsc_last, bar);
        end else begin
            beat({adr, d0}, 1'b0, 1'b0, 1'b0, bar);
            beat({d1, 32'h0}, 1'b0, 1'b1, dsc_last, bar);
        end
    endtask

    task automatic mwr4(input logic [31:0] hi, input logic [31:0] lo,
                        input logic [9:0] len, input logic [31:0] d0,
                        input logic [31:0] d1);
        beat({dw0(7'b11_00000, len), 32'h0000_000F}, 1'b1, 1'b0);
        beat({hi, lo}, 1'b0, 1'b0);
        beat({d0, d1}, 1'b0, 1'b1);
    endtask

    // Monitor: every output event consumes one scoreboard entry
    initial begin : monitor
        logic [64*NP-1:0] pa;
        logic [NP-1:0]    ps;
        exp_t             x;
        pa = '0;
        ps = '0;
        @(posedge reset_n);
        forever begin
            @(negedge trn_clk);
            if (hp_wr_err === 1'b1 || hp_addr !== pa || hp_status !== ps) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_event addr=%h status=%b err=%b",
                             hp_addr, hp_status, hp_wr_err);
                end else begin
                    x = exp_q.pop_front();
                    if (hp_addr !== x.a || hp_status !== x.s ||
                        hp_wr_err !== x.e) begin
                        miscompares++;
                        $display("FAIL event addr=%h exp %h status=%b exp %b err=%b exp %b",
                                 hp_addr, x.a, hp_status, x.s, hp_wr_err, x.e);
                    end
                end
            end
            pa = hp_addr;
            ps = hp_status;
        end
    end

    initial begin : stim
        reset_n        = 1'b0;
        trn_rd         = '0;
        trn_rrem_n     = '0;
        trn_rsof_n     = 1'b1;
        trn_reof_n     = 1'b1;
        trn_rsrc_rdy_n = 1'b1;
        trn_rsrc_dsc_n = 1'b1;
        trn_rbar_hit_n = '1;
        trn_rdst_rdy_n = 1'b0;
        hp_free        = '0;
        repeat (3) @(posedge trn_clk);
        #1;
        reset_n = 1'b1;

        vectors++;
        if (hp_addr !== '0 || hp_status !== '0 || hp_wr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset addr=%h status=%b err=%b exp all zero",
                     hp_addr, hp_status, hp_wr_err);
        end
        idle(2);

        // 3DW len 2 at 0x00 with destination and source stalls
        beat({dw0(7'b10_00000, 10'd2), 32'h0000_00FF}, 1'b1, 1'b0);
        beat({32'h0, 32'h7856_3412}, 1'b0, 1'b0, 1'b0, BAR2, 2);
        idle(2);
        ea[63:0] = 64'h9ABC_DEF0_1234_5678;
        push(1'b0);
        beat({32'hF0DE_BC9A, 32'h0}, 1'b0, 1'b1);
        idle(3);

        // 4DW len 1 at 0x10 -> page 2 low
        ea[159:128] = 32'hDEAD_BEEF;
        push(1'b0);
        mwr4(32'h0, 32'h10, 10'd1, 32'hEFBE_ADDE, 32'h0);
        idle(3);

        // 3DW len 2 at 0x04 straddles page 0 high and page 1 low
        ea[63:32] = 32'h1122_3344;
        ea[95:64] = 32'h5566_7788;
        push(1'b0);
        mwr3(32'h04, 10'd2, 32'h4433_2211, 32'h8877_6655, 1'b0, BAR2);
        idle(3);

        // 4DW len 2 at 0x18 fills page 3
        ea[223:192] = 32'h0102_0304;
        ea[255:224] = 32'h0506_0708;
        push(1'b0);
        mwr4(32'h0, 32'h18, 10'd2, 32'h0403_0201, 32'h0807_0605);
        idle(3);

        // Doorbell page 2 with a simultaneous free: set wins
        beat({dw0(7'b10_00000, 10'd1), 32'h0}, 1'b1, 1'b0);
        hp_free = 4'b0100;
        es = 4'b0100;
        push(1'b0);
        beat({32'h28, 32'hCAFE_F00D}, 1'b0, 1'b1);
        hp_free = '0;
        idle(3);
        es = 4'b0000;
        push(1'b0);
        hp_free = 4'b0100;
        idle(1);
        hp_free = '0;
        idle(3);

        // Doorbell pair for pages 2 and 3, then free both
        es = 4'b1100;
        push(1'b0);
        mwr3(32'h28, 10'd2, 32'h1, 32'h2, 1'b0, BAR2);
        idle(3);
        es = 4'b0000;
        push(1'b0);
        hp_free = 4'b1100;
        idle(1);
        hp_free = '0;
        idle(3);

        // Discontinue on the EOF beat
        push(1'b1);
        mwr3(32'h08, 10'd2, 32'h1111_1111, 32'h2222_2222, 1'b1, BAR2);
        idle(3);

        // High address bit set
        push(1'b1);
        mwr3(32'h40, 10'd1, 32'h3333_3333, 32'h0, 1'b0, BAR2);
        idle(3);

        // Pair runs one DW past the last doorbell
        push(1'b1);
        mwr3(32'h2C, 10'd2, 32'h4444_4444, 32'h5555_5555, 1'b0, BAR2);
        idle(3);

        // 4DW with nonzero upper address
        push(1'b1);
        mwr4(32'h1, 32'h0, 10'd1, 32'h6666_6666, 32'h0);
        idle(3);

        // Length 2 header with EOF on the address beat
        push(1'b1);
        beat({dw0(7'b10_00000, 10'd2), 32'h0}, 1'b1, 1'b0);
        beat({32'h0, 32'h7777_7777}, 1'b0, 1'b1);
        idle(3);

        // Other BAR, a read, then a bad length: only the last errors
        mwr3(32'h00, 10'd1, 32'h8888_8888, 32'h0, 1'b0, BAR0);
        idle(2);
        beat({dw0(7'b00_00000, 10'd1), 32'h0}, 1'b1, 1'b0);
        beat({32'h0, 32'h0}, 1'b0, 1'b1);
        idle(2);
        push(1'b1);
        beat({dw0(7'b10_00000, 10'd4), 32'h0}, 1'b1, 1'b0);
        beat({32'h0, 32'h9999_9999}, 1'b0, 1'b0);
        beat({32'h9999_9999, 32'h9999_9999}, 1'b0, 1'b0);
        beat({32'h9999_9999, 32'h0}, 1'b0, 1'b1);
        idle(3);

        // Reset during the DATA beat while the sink toggles ready
        beat({dw0(7'b10_00000, 10'd2), 32'h0}, 1'b1, 1'b0);
        beat({32'h0, 32'hAAAA_AAAA}, 1'b0, 1'b0);
        ea = '0;
        es = '0;
        push(1'b0);
        trn_rd         = {32'hBBBB_BBBB, 32'h0};
        trn_reof_n     = 1'b0;
        trn_rbar_hit_n = BAR2;
        trn_rsrc_rdy_n = 1'b0;
        reset_n        = 1'b0;
        for (int i = 0; i < 4; i++) begin
            trn_rdst_rdy_n = ~trn_rdst_rdy_n;
            @(posedge trn_clk);
            #1;
        end
        reset_n        = 1'b1;
        trn_rdst_rdy_n = 1'b0;
        idle(1);
        trn_rsrc_rdy_n = 1'b1;
        trn_reof_n     = 1'b1;
        trn_rbar_hit_n = '1;
        idle(3);

        // Fresh write after reset
        ea[255:224] = 32'hBAAD_F00D;
        push(1'b0);
        mwr3(32'h1C, 10'd1, 32'h0DF0_ADBA, 32'h0, 1'b0, BAR2);
        idle(5);

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_events pending=%0d exp 0", exp_q.size());
        end
        vectors++;
        if (hp_addr !== ea || hp_status !== es || hp_wr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL final addr=%h exp %h status=%b exp %b",
                     hp_addr, ea, hp_status, es);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
